// File: rtl/proc_pkg.sv
// Shared constants and FSM state encoding for the program-counter fetch sequencer.
package proc_pkg;
  localparam int PC_WIDTH     = 8;
  localparam int MEM_DEPTH    = 11;
  localparam int RESET_VECTOR = 0;
  localparam int OFF_WIDTH    = 5;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    S_BOOT  = ST_BOOT,
    S_RUN   = ST_RUN,
    S_HALT  = ST_HALT,
    S_FAULT = ST_FAULT
  } state_e;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: wrapped increment, jump/branch target and
// its out-of-range flag.
module pc_next_calc #(
  parameter int PC_WIDTH  = proc_pkg::PC_WIDTH,
  parameter int MEM_DEPTH = proc_pkg::MEM_DEPTH,
  parameter int OFF_WIDTH = proc_pkg::OFF_WIDTH
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 use_jump,
  input  logic [OFF_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic [PC_WIDTH-1:0]  inc_pc,
  output logic [PC_WIDTH-1:0]  tgt_pc,
  output logic                 tgt_oob
);
  logic [PC_WIDTH-1:0] off_sext;

  always_comb begin
    off_sext = {{(PC_WIDTH-OFF_WIDTH){branch_offset[OFF_WIDTH-1]}}, branch_offset};
    // Sequential fetch wraps at the end of memory instead of faulting.
    inc_pc   = (pc >= PC_WIDTH'(MEM_DEPTH-1)) ? '0 : pc + PC_WIDTH'(1);
    tgt_pc   = use_jump ? jump_target : pc + off_sext;
    tgt_oob  = (tgt_pc >= PC_WIDTH'(MEM_DEPTH));
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter stage: BOOT/RUN/HALT/FAULT sequencing of the fetch address.
// Optional PC_FETCH_COUNT_EN adds a saturating fetch_count output.
module pc_fetch_sequencer #(
  parameter int PC_WIDTH     = proc_pkg::PC_WIDTH,
  parameter int MEM_DEPTH    = proc_pkg::MEM_DEPTH,
  parameter int RESET_VECTOR = proc_pkg::RESET_VECTOR,
  parameter int OFF_WIDTH    = proc_pkg::OFF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 restart,
  input  logic                 branch_taken,
  input  logic [OFF_WIDTH-1:0] branch_offset,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic [PC_WIDTH-1:0]  pccounter,
  output logic                 pc_valid,
  output logic                 halted,
  output logic                 fault,
  output logic [PC_WIDTH-1:0]  fault_addr
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [15:0]          fetch_count
`endif
);
  import proc_pkg::*;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic                pc_valid_q, pc_valid_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [PC_WIDTH-1:0] inc_pc, tgt_pc;
  logic                tgt_oob;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),
    .OFF_WIDTH(OFF_WIDTH)
  ) u_next (
    .pc           (pc_q),
    .use_jump     (jump),
    .branch_offset(branch_offset),
    .jump_target  (jump_target),
    .inc_pc       (inc_pc),
    .tgt_pc       (tgt_pc),
    .tgt_oob      (tgt_oob)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // Restart acts as a jump to the reset vector through one BOOT bubble.
        if (restart) begin
          state_d = S_BOOT;
          pc_d    = PC_WIDTH'(RESET_VECTOR);
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump || branch_taken) begin
          if (tgt_oob) begin
            state_d      = S_FAULT;
            fault_addr_d = tgt_pc;
          end else begin
            pc_d = tgt_pc;
          end
        end else begin
          pc_d = inc_pc;
        end
      end
      S_HALT, S_FAULT: begin
        if (restart) begin
          state_d = S_BOOT;
          pc_d    = PC_WIDTH'(RESET_VECTOR);
        end
      end
      default: state_d = S_BOOT;
    endcase
    pc_valid_d = (state_d == S_RUN);
    halted_d   = (state_d == S_HALT);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= PC_WIDTH'(RESET_VECTOR);
      fault_addr_q <= '0;
      pc_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      pc_valid_q   <= pc_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign pccounter  = pc_q;
  assign pc_valid   = pc_valid_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

`ifdef PC_FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (state_q != S_BOOT && restart)
      fetch_count_d = '0;
    else if (state_q == S_RUN && !stall && fetch_count_q != 16'hFFFF)
      fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) fetch_count_q <= '0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, then random
// stimulus against a behavioural reference model.
module tb_pc_fetch_sequencer;
  logic       clock = 1'b0;
  logic       reset, stall, halt_req, restart, branch_taken, jump;
  logic [4:0] branch_offset;
  logic [7:0] jump_target, pccounter, fault_addr;
  logic       pc_valid, halted, fault;
`ifdef PC_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  pc_fetch_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .halt_req(halt_req),
    .restart(restart), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .pccounter(pccounter),
    .pc_valid(pc_valid), .halted(halted), .fault(fault), .fault_addr(fault_addr)
`ifdef PC_FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int pc, input int vld,
                         input int hal, input int flt, input int fa);
    chk({tag, " pccounter"},  int'(pccounter),  pc);
    chk({tag, " pc_valid"},   int'(pc_valid),   vld);
    chk({tag, " halted"},     int'(halted),     hal);
    chk({tag, " fault"},      int'(fault),      flt);
    chk({tag, " fault_addr"}, int'(fault_addr), fa);
  endtask

  task automatic drive(input bit stl, input bit hlt, input bit rs, input bit br,
                       input bit [4:0] off, input bit jmp, input bit [7:0] tgt);
    stall = stl; halt_req = hlt; restart = rs; branch_taken = br;
    branch_offset = off; jump = jmp; jump_target = tgt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit       stl, hlt, rs, br, jmp;
    bit [4:0] off;
    bit [7:0] tgt;
    int       pc, vld, hal, flt, fa;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit stl, bit hlt, bit rs, bit br, bit [4:0] off,
                              bit jmp, bit [7:0] tgt, int pc, int vld, int hal,
                              int flt, int fa);
    vec_t v;
    v.stl = stl; v.hlt = hlt; v.rs = rs; v.br = br; v.off = off;
    v.jmp = jmp; v.tgt = tgt; v.pc = pc; v.vld = vld; v.hal = hal;
    v.flt = flt; v.fa = fa;
    return v;
  endfunction

  // Reference model: state as a small integer code, arithmetic on plain ints.
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3, DEPTH = 11;
  int m_st, m_pc, m_fa, m_cnt;

  task automatic model_step();
    int t;
    if (reset) begin
      m_st = M_BOOT; m_pc = 0; m_fa = 0; m_cnt = 0;
    end else if (m_st == M_BOOT) begin
      m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (restart) begin
        m_st = M_BOOT; m_pc = 0; m_cnt = 0;
      end else begin
        if (!stall && m_cnt < 65535) m_cnt++;
        if (halt_req) m_st = M_HALT;
        else if (!stall && (jump || branch_taken)) begin
          if (jump) t = int'(jump_target);
          else t = (m_pc + int'($signed(branch_offset)) + 256) % 256;
          if (t >= DEPTH) begin m_st = M_FAULT; m_fa = t; end
          else m_pc = t;
        end else if (!stall) begin
          m_pc = (m_pc + 1) % DEPTH;
        end
      end
    end else if (restart) begin
      m_st = M_BOOT; m_pc = 0; m_cnt = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 0, 8'd0);
    step(); step();
    chk_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0, 0,1,0,0,0));
    for (int i = 1; i <= 10; i++) tv.push_back(mk(0,0,0,0,5'd0,0,8'd0, i,1,0,0,0));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0, 0,1,0,0,0));
    for (int i = 1; i <= 4; i++) tv.push_back(mk(0,0,0,0,5'd0,0,8'd0, i,1,0,0,0));
    tv.push_back(mk(0,0,0,1,5'b11110,0,8'd0, 2,1,0,0,0));
    tv.push_back(mk(0,0,0,1,5'd9,0,8'd0,     2,0,0,1,11));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,11));
    tv.push_back(mk(0,0,0,1,5'd3,1,8'd7,     7,1,0,0,11));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0,1,5'd1,1,8'd3, 7,1,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,1,8'd5,     5,1,0,0,11));
    tv.push_back(mk(0,1,0,0,5'd0,1,8'd9,     5,0,1,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,1,8'd2,     5,0,1,0,11));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     1,1,0,0,11));
    tv.push_back(mk(0,0,0,1,5'b11110,0,8'd0, 1,0,0,1,255));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,255));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,255));
    tv.push_back(mk(0,0,0,0,5'd0,1,8'd10,    10,1,0,0,255));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,255));
    tv.push_back(mk(0,0,0,0,5'd0,1,8'd11,    0,0,0,1,11));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     1,1,0,0,11));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,11));
    tv.push_back(mk(1,1,0,0,5'd0,0,8'd0,     0,0,1,0,11));
    tv.push_back(mk(0,0,1,0,5'd0,0,8'd0,     0,0,0,0,11));
    tv.push_back(mk(0,0,0,0,5'd0,0,8'd0,     0,1,0,0,11));

    foreach (tv[i]) begin
      drive(tv[i].stl, tv[i].hlt, tv[i].rs, tv[i].br, tv[i].off, tv[i].jmp, tv[i].tgt);
      step();
      chk_out($sformatf("vec%0d", i), tv[i].pc, tv[i].vld, tv[i].hal, tv[i].flt, tv[i].fa);
    end

    // Fetch counting, then reset in the middle of running.
    drive(0, 0, 0, 0, 5'd0, 0, 8'd0);
    reset = 1'b1; step(); reset = 1'b0;
`ifdef PC_FETCH_COUNT_EN
    chk("fetch_count reset", int'(fetch_count), 0);
`endif
    step();
    for (int i = 0; i < 8; i++) begin
      stall = (i == 3 || i == 4);
      step();
    end
    stall = 1'b0;
    chk("count run pc", int'(pccounter), 6);
`ifdef PC_FETCH_COUNT_EN
    chk("fetch_count 6", int'(fetch_count), 6);
`endif
    drive(0, 0, 0, 0, 5'd0, 1, 8'd20);
    step();
    drive(0, 0, 0, 0, 5'd0, 0, 8'd0);
    reset = 1'b1; step(); reset = 1'b0;
    chk_out("midreset", 0, 0, 0, 0, 0);
`ifdef PC_FETCH_COUNT_EN
    chk("fetch_count midreset", int'(fetch_count), 0);
`endif

    // Random phase against the reference model.
    reset = 1'b1;
    model_step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(99) == 0);
      restart       = ($urandom_range(24) == 0);
      halt_req      = ($urandom_range(24) == 0);
      stall         = ($urandom_range(5) == 0);
      jump          = ($urandom_range(7) == 0);
      branch_taken  = ($urandom_range(5) == 0);
      branch_offset = 5'($urandom);
      jump_target   = 8'($urandom_range(13));
      model_step();
      step();
      chk_out($sformatf("rand%0d", c), m_pc, int'(m_st == M_RUN),
              int'(m_st == M_HALT), int'(m_st == M_FAULT), m_fa);
`ifdef PC_FETCH_COUNT_EN
      chk($sformatf("rand%0d fetch_count", c), int'(fetch_count), m_cnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
